// File: rtl/byte_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : byte_mul_arbiter
// Brief   : Round-robin share of one 8x8 unsigned multiplier between two
//           requesters, returning tagged products on one response channel.
//           Define BYTE_MUL_ARB_PERF_EN to add busy-cycle / completed-op counters.
// Rev     : 1.0  initial release
// ============================================================================
module byte_mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_product
`ifdef BYTE_MUL_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_busy_cycles,
  output logic [CNT_W-1:0] perf_ops
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        cur_id_q, cur_id_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_product_q, rsp_product_d;

  logic        any_valid;
  logic        grant_id;
  logic [15:0] mul_product;

  // On a tie the requester that did not win last time is granted.
  assign any_valid   = req0_valid | req1_valid;
  assign grant_id    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign mul_product = {8'b0, op_a_q} * {8'b0, op_b_q};

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cur_id_d      = cur_id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_valid     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          op_a_d       = grant_id ? req1_a : req0_a;
          op_b_d       = grant_id ? req1_b : req0_b;
          cur_id_d     = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_MUL;
        end
      end
      ST_MUL: begin
        rsp_product_d = mul_product;
        rsp_id_d      = cur_id_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      cur_id_q      <= 1'b0;
      op_a_q        <= 8'd0;
      op_b_q        <= 8'd0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cur_id_q      <= cur_id_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

`ifdef BYTE_MUL_ARB_PERF_EN
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] ops_cnt_q, ops_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    ops_cnt_d  = ops_cnt_q;
    if ((state_q != ST_IDLE) && (busy_cnt_q != {CNT_W{1'b1}})) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end
    if ((state_q == ST_RESP) && rsp_ready && (ops_cnt_q != {CNT_W{1'b1}})) begin
      ops_cnt_d = ops_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
      ops_cnt_q  <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      ops_cnt_q  <= ops_cnt_d;
    end
  end

  assign perf_busy_cycles = busy_cnt_q;
  assign perf_ops         = ops_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_byte_mul_arbiter
// Brief   : Self-checking bench for byte_mul_arbiter against a round-robin /
//           arithmetic reference model. Perf checks use BYTE_MUL_ARB_PERF_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_byte_mul_arbiter;

  localparam int CNT_W = 16;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_product;
`ifdef BYTE_MUL_ARB_PERF_EN
  logic [CNT_W-1:0] perf_busy_cycles, perf_ops;
`endif

  int   n_checks;
  int   n_errors;
  logic m_last;  // model of which requester won the previous grant

  byte_mul_arbiter #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
`ifdef BYTE_MUL_ARB_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_ops         (perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE back to IDLE, with bp stall cycles in RESP.
  task automatic run_op(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                        input int bp);
    logic exp_id;
    int   exp_prod;
    if (v0 && v1) exp_id = ~m_last;
    else          exp_id = v1;
    exp_prod = exp_id ? (int'(a1) * int'(b1)) : (int'(a0) * int'(b0));

    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;

    @(negedge clk);
    n_checks++;
    if (req0_ready !== (v0 && exp_id == 1'b0)) begin
      n_errors++;
      $display("FAIL idle_req0_ready: got %b expected %b", req0_ready, (v0 && exp_id == 1'b0));
    end
    n_checks++;
    if (req1_ready !== (v1 && exp_id == 1'b1)) begin
      n_errors++;
      $display("FAIL idle_req1_ready: got %b expected %b", req1_ready, (v1 && exp_id == 1'b1));
    end
    next_cycle();
    m_last = exp_id;

    // Requesters keep their valids up while the operation is in flight.
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_cycle: got valid=%b r0=%b r1=%b expected all 0",
               rsp_valid, req0_ready, req1_ready);
    end
    next_cycle();

    for (int i = 0; i <= bp; i++) begin
      rsp_ready = (i == bp);
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL resp_valid: got %b expected 1 (stall %0d)", rsp_valid, i);
      end
      n_checks++;
      if (rsp_product !== exp_prod[15:0]) begin
        n_errors++;
        $display("FAIL resp_product: got %0d expected %0d (stall %0d)", rsp_product, exp_prod, i);
      end
      n_checks++;
      if (rsp_id !== exp_id) begin
        n_errors++;
        $display("FAIL resp_id: got %b expected %b (stall %0d)", rsp_id, exp_id, i);
      end
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL resp_ready_low: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
      end
      next_cycle();
    end
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_product !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%b id=%b prod=%0d expected 0 0 0",
               rsp_valid, rsp_id, rsp_product);
    end
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
    end
`ifdef BYTE_MUL_ARB_PERF_EN
    n_checks++;
    if (perf_busy_cycles !== '0 || perf_ops !== '0) begin
      n_errors++;
      $display("FAIL reset_perf: got busy=%0d ops=%0d expected 0 0", perf_busy_cycles, perf_ops);
    end
`endif
    next_cycle();

    // Reset arriving together with a request must win: nothing is accepted.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
    req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd3;
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_priority: got rsp_valid=%b expected 0 (cycle %0d)", rsp_valid, i);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_op();
    run_op(1'b1, 8'd105, 8'd26, 1'b0, 8'd0, 8'd0, 0);
  endtask

  task automatic test_tie();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_last = 1'b1;
    run_op(1'b1, 8'd3, 8'd4, 1'b1, 8'd5, 8'd6, 0);
    run_op(1'b1, 8'd3, 8'd4, 1'b1, 8'd5, 8'd6, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 0);
    end
    // A lone requester is always granted.
    run_op(1'b0, 8'd0, 8'd0, 1'b1, 8'd11, 8'd12, 0);
    run_op(1'b0, 8'd0, 8'd0, 1'b1, 8'd13, 8'd14, 0);
    run_op(1'b1, 8'd20, 8'd21, 1'b1, 8'd22, 8'd23, 0);
  endtask

  task automatic test_corners();
    run_op(1'b1, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0, 0);
    run_op(1'b0, 8'd0, 8'd0, 1'b1, 8'd0, 8'd200, 0);
    run_op(1'b1, 8'd1, 8'd255, 1'b0, 8'd0, 8'd0, 0);
  endtask

  task automatic test_back_pressure();
    run_op(1'b1, 8'd200, 8'd3, 1'b1, 8'd17, 8'd19, 5);
    run_op(1'b1, 8'd200, 8'd3, 1'b1, 8'd17, 8'd19, 5);
  endtask

  task automatic test_reset_in_mul();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd10;
    next_cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_product !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_in_mul: got valid=%b prod=%0d expected 0 0 (cycle %0d)",
                 rsp_valid, rsp_product, i);
      end
      next_cycle();
    end
    run_op(1'b1, 8'd6, 8'd7, 1'b1, 8'd8, 8'd9, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_op(v0, 8'($urandom), 8'($urandom), v1, 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)));
    end
  endtask

`ifdef BYTE_MUL_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'd0, 8'd0, 0);
    end
    @(negedge clk);
    n_checks++;
    if (perf_ops !== CNT_W'(3)) begin
      n_errors++;
      $display("FAIL perf_ops: got %0d expected 3", perf_ops);
    end
    n_checks++;
    if (perf_busy_cycles !== CNT_W'(6)) begin
      n_errors++;
      $display("FAIL perf_busy_cycles: got %0d expected 6", perf_busy_cycles);
    end
    next_cycle();
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_last     = 1'b1;
    rst        = 1'b1;
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0;
    rsp_ready  = 1'b0;
    #1;

    test_reset();
    test_single_op();
    test_tie();
    test_corners();
    test_back_pressure();
    test_reset_in_mul();
    test_random();
`ifdef BYTE_MUL_ARB_PERF_EN
    test_perf();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
